pipe_adder: RTL

Parametrised, pipelined two-operand adder with a valid/ready stream interface.
- Configurable in width, pipeline depth and carry-in mode (half-adder style or full-adder style).
- Splits the operands into `STAGES` equal slices; each pipeline stage adds one slice and registers the carry forward.
- Sits between operand-producing datapath blocks and result consumers that can apply backpressure.

---
 rtl/pipe_adder_pkg.sv | 21 ++
 rtl/pipe_adder_stage.sv | 60 ++++++
 rtl/pipe_adder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared types and helpers for the pipelined adder.
//   adder_type_e : carry-in mode selector (ADD_HALF ignores in_cin,
//                  ADD_FULL adds in_cin at bit 0)
//   slice_w()    : width of the operand slice handled by one pipeline stage
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

  typedef enum logic {
    ADD_HALF = 1'b0,
    ADD_FULL = 1'b1
  } adder_type_e;

  // A zero stage count is rejected at elaboration by the top level; returning
  // 0 here keeps the constant evaluation itself free of a divide by zero.
  function automatic int slice_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 0;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// -----------------------------------------------------------------------------
// pipe_adder_stage
// One slice of the pipelined adder: adds an SW-bit slice of A and B plus the
// incoming carry and registers {carry, sum_slice} together with a valid bit.
// The whole stage holds while en is low (downstream stall).
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (valid bit only)
//   en         : advance enable, low while the pipe is stalled
//   vld_in     : valid of the beat presented to this stage
//   a, b       : operand slices
//   cin        : carry from the previous stage (or the adder carry-in)
//   vld_out    : registered valid
//   sum        : registered slice sum
//   cout       : registered slice carry-out
// -----------------------------------------------------------------------------
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          vld_in,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic          vld_out,
  output logic [SW-1:0] sum,
  output logic          cout
);

  logic [SW:0] total;
  logic [SW:0] res_p0;
  logic        vld_p0;

  assign total = {1'b0, a} + {1'b0, b} + (SW + 1)'(cin);

  // ---- stage register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
    end else if (en) begin
      vld_p0 <= vld_in;
    end
  end

  // Data is not reset: a bubble may carry a stale value, which is harmless
  // because every consumer qualifies it with the valid bit.
  always_ff @(posedge clk) begin
    if (en) begin
      res_p0 <= total;
    end
  end

  assign vld_out     = vld_p0;
  assign {cout, sum} = res_p0;

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Pipelined two-operand unsigned adder with a valid/ready stream interface.
// The operands are cut into STAGES slices of SW = WIDTH/STAGES bits; stage k
// adds slice k and forwards its carry to stage k+1. Operands travel down the
// pipe so later stages find their slice, and finished lower sum slices travel
// alongside in skew registers until the last stage completes the word.
//
// Parameters
//   WIDTH      : operand / sum width, multiple of STAGES
//   STAGES     : pipeline depth, 1..WIDTH (latency in cycles)
//   ADDER_TYPE : 0 = half mode (in_cin ignored), 1 = full mode
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake; in_ready = !(out_valid && !out_ready)
//   in_a, in_b, in_cin  : operands and carry-in
//   out_valid/out_ready : output handshake
//   out_sum, out_cout   : (in_a + in_b + cin) mod 2^WIDTH and its carry-out
//   out_ovf             : signed overflow, only when PIPE_ADDER_OVF_EN is
//                         defined
//
// Outputs are forced to zero whenever out_valid is low, which also gives the
// all-zero output state during reset without resetting the data registers.
// -----------------------------------------------------------------------------
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 4,
  parameter int ADDER_TYPE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int SW   = slice_w(WIDTH, STAGES);
  localparam int LAST = (STAGES > 0) ? STAGES - 1 : 0;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $fatal(1, "pipe_adder: STAGES=%0d must be in 1..WIDTH (%0d)", STAGES, WIDTH);
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $fatal(1, "pipe_adder: WIDTH=%0d is not a multiple of STAGES=%0d", WIDTH, STAGES);
  end
  if (ADDER_TYPE < 0 || ADDER_TYPE > 1) begin : g_bad_type
    $fatal(1, "pipe_adder: ADDER_TYPE=%0d must be 0 or 1", ADDER_TYPE);
  end

  logic stall;
  logic en;
  logic cin0;

  // Per-stage signals; index k is the register set after stage k.
  logic             vld_src [STAGES];
  logic             cin_src [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] lo_src  [STAGES];
  logic [WIDTH-1:0] a_p     [STAGES];
  logic [WIDTH-1:0] b_p     [STAGES];
  logic [WIDTH-1:0] lo_p    [STAGES];
  logic [WIDTH-1:0] acc     [STAGES];
  logic             vld     [STAGES];
  logic             carry   [STAGES];
  logic [SW-1:0]    ssum    [STAGES];

  // Handshake: everything advances unless a finished beat is waiting.
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  case (ADDER_TYPE)
    int'(ADD_FULL): begin : g_full
      assign cin0 = in_cin;
    end
    default: begin : g_half
      logic cin_unused;
      assign cin0       = 1'b0;
      assign cin_unused = in_cin;
    end
  endcase

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_src[k] = in_valid;
      assign cin_src[k] = cin0;
      assign a_src[k]   = in_a;
      assign b_src[k]   = in_b;
      assign lo_src[k]  = '0;
    end else begin : g_body
      assign vld_src[k] = vld[k-1];
      assign cin_src[k] = carry[k-1];
      assign a_src[k]   = a_p[k-1];
      assign b_src[k]   = b_p[k-1];
      assign lo_src[k]  = acc[k-1];
    end

    pipe_adder_stage #(
      .SW (SW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .vld_in  (vld_src[k]),
      .a       (a_src[k][k*SW +: SW]),
      .b       (b_src[k][k*SW +: SW]),
      .cin     (cin_src[k]),
      .vld_out (vld[k]),
      .sum     (ssum[k]),
      .cout    (carry[k])
    );

    // ---- stage k skew registers: operands and finished lower slices ----
    always_ff @(posedge clk) begin
      if (en) begin
        a_p[k]  <= a_src[k];
        b_p[k]  <= b_src[k];
        lo_p[k] <= lo_src[k];
      end
    end

    // Partial sum after stage k: skewed lower slices with slice k dropped in.
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}}) << (k * SW);
    assign acc[k] = (lo_p[k] & ~SLICE_MASK) | (WIDTH'(ssum[k]) << (k * SW));
  end

  assign out_valid = vld[LAST];
  assign out_sum   = out_valid ? acc[LAST] : '0;
  assign out_cout  = out_valid & carry[LAST];

`ifdef PIPE_ADDER_OVF_EN
  // Operand MSBs of the beat in the last stage sit in its operand registers.
  assign out_ovf = out_valid
                 & (a_p[LAST][WIDTH-1] == b_p[LAST][WIDTH-1])
                 & (acc[LAST][WIDTH-1] != a_p[LAST][WIDTH-1]);
`endif

endmodule
